// File: rtl/gc_cmd_rx.sv
// Joybus console-line receiver: synchronises the line, decodes pulse-width bits and
// presents each complete 8- or 24-bit console command with a one-cycle strobe.
module gc_cmd_rx #(
    parameter int CYC_PER_US  = 25,
    parameter int GLITCH_CYC  = 3,
    parameter int THRESH_CYC  = 2 * CYC_PER_US,
    parameter int MAX_LOW_CYC = 5 * CYC_PER_US,
    parameter int END_CYC     = 5 * CYC_PER_US
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_jb_in,
    input  logic        i_rx_en,
    output logic [23:0] o_cmd,
    output logic [1:0]  o_cmd_bytes,
    output logic        o_cmd_valid,
    output logic        o_frame_err,
    output logic        o_rx_busy,
    output logic [1:0]  o_dbg_state
);

    localparam int TW = $clog2(MAX_LOW_CYC + 2);
    localparam logic [TW-1:0] T_SAT    = TW'(MAX_LOW_CYC + 1);
    localparam logic [TW-1:0] T_MAX    = TW'(MAX_LOW_CYC);
    localparam logic [TW-1:0] T_END    = TW'(END_CYC - 1);
    localparam logic [TW-1:0] T_GLITCH = TW'(GLITCH_CYC);
    localparam logic [TW-1:0] T_THRESH = TW'(THRESH_CYC);

    typedef enum logic [1:0] {
        S_WAIT_HIGH = 2'd0,
        S_IDLE      = 2'd1,
        S_LOW       = 2'd2,
        S_HIGH      = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_sync1, r_sync2, r_prev;
    logic [TW-1:0] r_timer;
    logic [24:0]   r_shift;
    logic [4:0]    r_cnt;
    logic          r_ovf;
    logic [23:0]   r_cmd;
    logic [1:0]    r_bytes;
    logic          r_valid, r_err;

    logic w_rise, w_fall, w_edge, w_glitch, w_bit;
    logic w_start, w_push, w_eof, w_abort;
    logic w_ok9, w_ok25;

    assign w_rise   = r_sync2 & ~r_prev;
    assign w_fall   = ~r_sync2 & r_prev;
    assign w_edge   = w_rise | w_fall;
    assign w_glitch = (r_timer <= T_GLITCH);
    assign w_bit    = (r_timer < T_THRESH);
    assign w_ok9    = (r_cnt == 5'd9) && !r_ovf && r_shift[0];
    assign w_ok25   = (r_cnt == 5'd25) && !r_ovf && r_shift[0];

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_push      = 1'b0;
        w_eof       = 1'b0;
        w_abort     = 1'b0;
        unique case (r_state)
            S_WAIT_HIGH: if (r_sync2) w_state_nxt = S_IDLE;
            S_IDLE: begin
                if (w_fall) begin
                    w_state_nxt = S_LOW;
                    w_start     = 1'b1;
                end
            end
            S_LOW: begin
                // An edge coinciding with the timeout wins over the timeout.
                if (w_rise) begin
                    if (w_glitch) begin
                        w_state_nxt = (r_cnt == 5'd0) ? S_IDLE : S_HIGH;
                    end else begin
                        w_push      = 1'b1;
                        w_state_nxt = S_HIGH;
                    end
                end else if (r_timer > T_MAX) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_WAIT_HIGH;
                end
            end
            S_HIGH: begin
                if (w_fall) begin
                    w_state_nxt = S_LOW;
                end else if (r_timer == T_END) begin
                    w_eof       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
        if (!i_rx_en) begin
            w_state_nxt = S_WAIT_HIGH;
            w_start     = 1'b0;
            w_push      = 1'b0;
            w_eof       = 1'b0;
            w_abort     = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_timer <= '0;
            r_state <= S_WAIT_HIGH;
            r_shift <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_cmd   <= '0;
            r_bytes <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_sync1 <= i_jb_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            // Counts cycles spent at the current level, the edge cycle included.
            if (w_edge) begin
                r_timer <= TW'(1);
            end else if (r_timer != T_SAT) begin
                r_timer <= r_timer + TW'(1);
            end
            r_state <= w_state_nxt;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (w_start) begin
                r_shift <= '0;
                r_cnt   <= '0;
                r_ovf   <= 1'b0;
            end
            if (w_push) begin
                r_shift <= {r_shift[23:0], w_bit};
                if (r_cnt == 5'd25) r_ovf <= 1'b1;
                else                r_cnt <= r_cnt + 5'd1;
            end
            if (w_abort) r_err <= 1'b1;
            if (w_eof) begin
                if (w_ok9) begin
                    r_cmd   <= {r_shift[8:1], 16'h0000};
                    r_bytes <= 2'd1;
                    r_valid <= 1'b1;
                end else if (w_ok25) begin
                    r_cmd   <= r_shift[24:1];
                    r_bytes <= 2'd3;
                    r_valid <= 1'b1;
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign o_cmd       = r_cmd;
    assign o_cmd_bytes = r_bytes;
    assign o_cmd_valid = r_valid;
    assign o_frame_err = r_err;
    assign o_rx_busy   = i_rx_en && ((r_state == S_LOW) || (r_state == S_HIGH));
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_gc_cmd_rx.sv
// Bench for gc_cmd_rx: drives Joybus frames and checks strobes, command hold and
// busy behaviour against a frame-level model of the receiver.
module tb_gc_cmd_rx;

    localparam int CYC_PER_US  = 25;
    localparam int MAX_LOW_CYC = 5 * CYC_PER_US;
    localparam int END_CYC     = 5 * CYC_PER_US;
    localparam int US1         = CYC_PER_US;
    localparam int US3         = 3 * CYC_PER_US;

    logic        clk = 1'b0;
    logic        rst;
    logic        jb_in;
    logic        rx_en;
    logic [23:0] cmd;
    logic [1:0]  cmd_bytes;
    logic        cmd_valid;
    logic        frame_err;
    logic        rx_busy;
    logic [1:0]  dbg_state;

    gc_cmd_rx dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_jb_in     (jb_in),
        .i_rx_en     (rx_en),
        .o_cmd       (cmd),
        .o_cmd_bytes (cmd_bytes),
        .o_cmd_valid (cmd_valid),
        .o_frame_err (frame_err),
        .o_rx_busy   (rx_busy),
        .o_dbg_state (dbg_state)
    );

    // ---- clock / reset ----
    always #20 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---- scoreboard: {is_err, bytes, cmd} plus allowed strobe cycle window ----
    logic [26:0] exp_q[$];
    int          exp_lo_q[$];
    int          exp_hi_q[$];
    logic [23:0] hold_cmd   = 24'h0;
    logic [1:0]  hold_bytes = 2'd0;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [26:0] model_frame(input logic [23:0] data, input int ndata,
                                                input logic stop);
        int total;
        total = ndata + 1;
        if (stop && total == 9)  return {1'b0, 2'd1, data[7:0], 16'h0000};
        if (stop && total == 25) return {1'b0, 2'd3, data};
        return {1'b1, 2'd0, 24'h0};
    endfunction

    logic [26:0] e;
    int          lo, hi;
    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_valid || frame_err) begin
                checks++;
                if (cmd_valid && frame_err) begin
                    errors++;
                    $display("FAIL both_strobes: cmd_valid=1 frame_err=1 at cycle %0d, required at most one", cyc);
                end
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: cmd_valid=%0b frame_err=%0b at cycle %0d, required none",
                             cmd_valid, frame_err, cyc);
                end else begin
                    e  = exp_q.pop_front();
                    lo = exp_lo_q.pop_front();
                    hi = exp_hi_q.pop_front();
                    checks++;
                    if (e[26] != frame_err) begin
                        errors++;
                        $display("FAIL strobe_kind: frame_err=%0b cmd_valid=%0b, required frame_err=%0b",
                                 frame_err, cmd_valid, e[26]);
                    end
                    if (!e[26]) begin
                        hold_cmd   = e[23:0];
                        hold_bytes = e[25:24];
                    end
                    checks++;
                    if (cyc < lo || cyc > hi) begin
                        errors++;
                        $display("FAIL strobe_time: cycle %0d, required %0d..%0d", cyc, lo, hi);
                    end
                end
            end
            checks++;
            if (cmd !== hold_cmd || cmd_bytes !== hold_bytes) begin
                errors++;
                $display("FAIL cmd_hold: cmd=%h bytes=%0d at cycle %0d, required cmd=%h bytes=%0d",
                         cmd, cmd_bytes, cyc, hold_cmd, hold_bytes);
            end
        end
    end

    // ---- driver tasks ----
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic drive(input logic v, input int n);
        jb_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        drive(1'b0, b ? US1 : US3);
        check("busy_in_bit", {31'd0, rx_busy}, 32'd1);
        if (glitch && b) begin
            drive(1'b1, 30);
            drive(1'b0, 2);
            drive(1'b1, US3 - 32);
        end else begin
            drive(1'b1, b ? US3 : US1);
        end
    endtask

    task automatic expect_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_strobe: %0d outstanding, required 0", name, exp_q.size());
            exp_q.delete();
            exp_lo_q.delete();
            exp_hi_q.delete();
        end
    endtask

    task automatic send_frame(input logic [23:0] data, input int ndata, input logic stop,
                              input int glitch_idx);
        logic [26:0] m;
        m = model_frame(data, ndata, stop);
        for (int i = 0; i < ndata; i++) send_bit(data[ndata-1-i], i == glitch_idx);
        drive(1'b0, stop ? US1 : US3);
        jb_in = 1'b1;
        exp_q.push_back(m);
        exp_lo_q.push_back(cyc + END_CYC + 2);
        exp_hi_q.push_back(cyc + END_CYC + 2);
        repeat (200) @(posedge clk);
        #1;
        check("busy_after_frame", {31'd0, rx_busy}, 32'd0);
        expect_drained("frame");
    endtask

    task automatic partial_400302();
        logic [23:0] d;
        d = 24'h400302;
        for (int i = 0; i < 10; i++) send_bit(d[23-i], 1'b0);
        drive(1'b0, 10);
    endtask

    // ---- stimulus ----
    initial begin
        rst   = 1'b1;
        jb_in = 1'b1;
        rx_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_cmd", {8'd0, cmd}, 32'd0);
        check("rst_bytes", {30'd0, cmd_bytes}, 32'd0);
        check("rst_valid", {31'd0, cmd_valid}, 32'd0);
        check("rst_err", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, rx_busy}, 32'd0);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        send_frame(24'h400301, 24, 1'b1, -1);
        check("lit_cmd_400301", {8'd0, cmd}, 32'h00400301);
        check("lit_bytes_3", {30'd0, cmd_bytes}, 32'd3);

        send_frame(24'h000000, 8, 1'b1, -1);
        check("lit_cmd_00", {8'd0, cmd}, 32'h00000000);
        check("lit_bytes_1", {30'd0, cmd_bytes}, 32'd1);

        send_frame(24'h000041, 8, 1'b1, 1);
        check("lit_cmd_41", {8'd0, cmd}, 32'h00410000);

        send_frame(24'h00abcd, 16, 1'b1, -1);
        check("lit_cmd_kept", {8'd0, cmd}, 32'h00410000);
        send_frame(24'h400301, 24, 1'b1, -1);

        send_frame(24'h00005a, 8, 1'b0, -1);
        check("lit_cmd_after_bad_stop", {8'd0, cmd}, 32'h00400301);

        // five bits, then the line stuck low for 6 us
        for (int i = 0; i < 5; i++) send_bit(i[0], 1'b0);
        jb_in = 1'b0;
        exp_q.push_back({1'b1, 2'd0, 24'h0});
        exp_lo_q.push_back(cyc + MAX_LOW_CYC + 1);
        exp_hi_q.push_back(cyc + MAX_LOW_CYC + 5);
        drive(1'b0, 6 * US1);
        drive(1'b1, 200);
        check("busy_after_abort", {31'd0, rx_busy}, 32'd0);
        expect_drained("abort");
        send_frame(24'h000000, 8, 1'b1, -1);
        check("lit_cmd_00_after_abort", {8'd0, cmd}, 32'h00000000);

        // reset in the middle of a frame
        send_frame(24'h400301, 24, 1'b1, -1);
        partial_400302();
        rst        = 1'b1;
        hold_cmd   = 24'h0;
        hold_bytes = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        check("busy_in_reset", {31'd0, rx_busy}, 32'd0);
        rst = 1'b0;
        drive(1'b1, 300);
        check("busy_after_reset", {31'd0, rx_busy}, 32'd0);
        expect_drained("reset");
        send_frame(24'h400301, 24, 1'b1, -1);
        check("lit_cmd_after_reset", {8'd0, cmd}, 32'h00400301);

        // enable dropped in the middle of a frame
        send_frame(24'h000000, 8, 1'b1, -1);
        partial_400302();
        rx_en = 1'b0;
        #1;
        check("busy_rx_en_off", {31'd0, rx_busy}, 32'd0);
        drive(1'b0, 5);
        drive(1'b1, 300);
        check("busy_rx_en_off_idle", {31'd0, rx_busy}, 32'd0);
        rx_en = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        expect_drained("rx_en");
        send_frame(24'h400301, 24, 1'b1, -1);
        check("lit_cmd_after_rx_en", {8'd0, cmd}, 32'h00400301);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gc_cmd_rx.md
Name: gc_cmd_rx

Overview:
- Joybus receive front end for the console-side line of the GameCube XY-injection path.
- Samples the single-wire console line and decodes the pulse-width-encoded bits.
- Delimits frames on the stop bit and presents each complete console command (8- or 24-bit) with a one-cycle strobe to the injection/response logic downstream.
- Also provides a busy flag, so the transmitter can avoid driving the line while a command is still arriving.

Parameters:
- CYC_PER_US, 25: clock cycles per microsecond (40 ns clock).
- GLITCH_CYC, 3: low pulses this long or shorter are ignored as noise.
- THRESH_CYC, 2*CYC_PER_US: low-time threshold that separates bit 1 from bit 0.
- MAX_LOW_CYC, 5*CYC_PER_US: any low time longer than this aborts the frame.
- END_CYC, 5*CYC_PER_US: high time that marks end of frame.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- jb_in  in  1  raw console Joybus line (asynchronous; released = 1).
- rx_en  in  1  decode enable; deasserted while the local transmitter owns the line.
- cmd  out  24  received command, left-aligned; unused low bits = 0.
- cmd_bytes  out  2  byte count of cmd: 1 or 3.
- cmd_valid  out  1  one-cycle strobe; cmd and cmd_bytes are valid this cycle.
- frame_err  out  1  one-cycle strobe on a malformed or aborted frame.
- rx_busy  out  1  high from the first accepted falling edge until the frame ends or aborts.

Behaviour:
- Reset values: cmd=0, cmd_bytes=0, cmd_valid=0, frame_err=0, rx_busy=0. FSM enters WAIT_HIGH. Shift register, bit count and timer are cleared.
- Input sync: jb_in passes through a 2-flop synchronizer into jb_s. All timing below is relative to jb_s.
- Edge detect on jb_s against its registered copy.
- Timer: one counter, cleared on every jb_s edge, saturating at MAX_LOW_CYC+1.
- Bit rule at each rising edge: low time ≤ GLITCH_CYC is discarded (no bit, timer keeps running as high). low time < THRESH_CYC gives bit 1; otherwise bit 0.
- FSM states:
  - WAIT_HIGH: wait for jb_s=1 → IDLE. Ensures reset or enable release mid-pulse never decodes a partial bit.
  - IDLE: falling edge → LOW. Clears the shift register and bit count, sets rx_busy.
  - LOW: rising edge → classify. A valid bit is shifted into a 25-bit register (MSB first), bit count +1, → HIGH. A glitch returns to HIGH without a bit, or to IDLE if no bits yet. Timer > MAX_LOW_CYC → frame_err pulse, rx_busy=0 → WAIT_HIGH.
  - HIGH: falling edge → LOW. Timer reaches END_CYC → end-of-frame check, → IDLE, rx_busy=0.
- End-of-frame check: the last received bit is the stop bit and must be 1.
  - If the bit count is 9: cmd={bits[8:1],16'h0}, cmd_bytes=1.
  - If the bit count is 25: cmd=bits[24:1], cmd_bytes=3.
  - Either case pulses cmd_valid.
  - Any other count, bit count overflow beyond 25, or a stop bit of 0 pulses frame_err instead. cmd is unchanged in that case.
- Latency: cmd_valid rises exactly END_CYC cycles after the synchronized stop-bit rising edge, i.e. END_CYC+2 cycles after the jb_in rising edge.
- cmd and cmd_bytes hold their value until the next valid frame.
- rx_en=0: FSM forced to WAIT_HIGH every cycle, rx_busy=0, no strobes. Deasserting mid-frame aborts silently, with no frame_err.
- rst mid-frame: same as reset. The partial frame is lost and no strobe is issued.
- Simultaneous events: cmd_valid and frame_err are never asserted in the same cycle.
- Simultaneous events: an edge in the same cycle the timer hits its limit takes priority, and the timer event is ignored.

Test Plan:
- 24'h400301 + stop bit, 1 µs/3 µs timing → single cmd_valid END_CYC+2 cycles after the stop rising edge. cmd=24'h400301, cmd_bytes=3, frame_err never set, rx_busy high throughout the frame.
- 8'h00 + stop → cmd=24'h000000, cmd_bytes=1, cmd_valid once.
- 8'h41 + stop with a 2-cycle low glitch inside one high phase → cmd=24'h410000, cmd_bytes=1, no frame_err.
- 16 data bits + stop → frame_err pulse, no cmd_valid, cmd keeps its previous value. Then 24'h400301 → normal decode.
- Line held low 6 µs after 5 bits → frame_err at MAX_LOW_CYC+1 cycles of low, and nothing decodes until the line returns high. Then 8'h00 decodes.
- Reset asserted, and separately rx_en deasserted, in the middle of 24'h400302 → no strobes, rx_busy=0. Following 24'h400301 → cmd=24'h400301.
